// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch front end.
// Bundle width is a module parameter, so the entry struct lives in fetch_unit.
package fetch_pkg;

    localparam int unsigned PC_W = 64;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

    function automatic logic [PC_W-1:0] pc_align(input logic [PC_W-1:0] pc,
                                                 input int unsigned      step);
        return pc & ~(PC_W'(step) - 64'd1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head is the oldest registered entry.
// Zero-latency head visibility; push when full is dropped (caller guarantees space).
module fetch_fifo #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_push_dat,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic [DATA_W-1:0]        o_head_dat
);

    localparam int unsigned    PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_do_push  = i_push && (r_count != FULL_CNT);
    assign w_do_pop   = i_pop && (r_count != '0);
    assign o_count    = r_count;
    assign o_full     = (r_count == FULL_CNT);
    assign o_head_dat = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{PTR_W{1'b0}}, w_do_push} - {{PTR_W{1'b0}}, w_do_pop};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Owns the PC, issues one MMU fetch at a time, buffers PC-tagged bundles for decode.
// One IDLE cycle between requests; issue stalls while the output FIFO is full.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned INSTRUCTIONSIZE = 64,
    parameter logic [63:0] RESET_PC        = 64'h0,
    parameter int unsigned DEPTH           = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [63:0]                fetch_address,
    output logic                       fetch_req,
    input  logic [INSTRUCTIONSIZE-1:0] fetch_instruction,
    input  logic                       fetch_done,
    input  logic                       redirect_valid,
    input  logic [63:0]                redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTRUCTIONSIZE-1:0] out_instruction,
    output logic [63:0]                out_pc
);

    localparam int unsigned       STEP        = INSTRUCTIONSIZE / 8;
    localparam int unsigned       CNT_W       = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT   = CNT_W'(DEPTH);
    localparam logic [63:0]       STEP_PC     = 64'(STEP);
    localparam logic [63:0]       RESET_PC_AL = pc_align(RESET_PC, STEP);

    typedef struct packed {
        logic [INSTRUCTIONSIZE-1:0] instruction;
        logic [63:0]                pc;
    } fetch_entry_t;

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [63:0]      r_pc;
    logic             r_drop;
    logic             r_fetch_req;
    logic [63:0]      r_fetch_addr;
    logic             w_issue;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_flush;
    logic             w_full;
    logic [CNT_W-1:0] w_count;
    fetch_entry_t     w_push_entry;
    fetch_entry_t     w_head_entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (!redirect_valid && (w_count < DEPTH_CNT)) w_state_nxt = WAIT;
            WAIT:    if (fetch_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Redirect wins over both the push of a returning bundle and a decode pop.
    always_comb begin
        w_issue  = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            IDLE:    w_issue  = !redirect_valid && (w_count < DEPTH_CNT);
            WAIT:    w_accept = fetch_done;
            default: ;
        endcase
        w_flush = redirect_valid;
        w_push  = w_accept && !r_drop && !redirect_valid;
        w_pop   = out_valid && out_ready && !redirect_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC_AL;
            r_drop       <= 1'b0;
            r_fetch_req  <= 1'b0;
            r_fetch_addr <= RESET_PC_AL;
        end else begin
            if (w_issue) begin
                r_fetch_req  <= 1'b1;
                r_fetch_addr <= r_pc;
            end else if (w_accept) begin
                r_fetch_req  <= 1'b0;
            end

            if (redirect_valid) begin
                r_pc <= pc_align(redirect_pc, STEP);
            end else if (w_push) begin
                r_pc <= r_pc + STEP_PC;
            end

            // The MMU cannot be cancelled, so a stale response is marked for discard.
            if (w_accept) begin
                r_drop <= 1'b0;
            end else if (redirect_valid && (r_state == WAIT)) begin
                r_drop <= 1'b1;
            end
        end
    end

    assign w_push_entry = '{instruction: fetch_instruction, pc: r_pc};

    fetch_fifo #(
        .DATA_W ($bits(fetch_entry_t)),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_push_dat (w_push_entry),
        .i_pop      (w_pop),
        .i_flush    (w_flush),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_head_dat (w_head_entry)
    );

    assign fetch_req       = r_fetch_req;
    assign fetch_address   = r_fetch_addr;
    assign out_valid       = (w_count != '0);
    assign out_instruction = w_head_entry.instruction;
    assign out_pc          = w_head_entry.pc;

    // Space is reserved at issue time with one request outstanding.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(w_push && w_full));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed phases plus a random phase against a queue-based reference of the fetch stream.
module tb_fetch_unit;

    localparam int          DEPTH = 2;
    localparam int          STEP  = 8;
    localparam logic [63:0] RST_PC = 64'h1000;

    logic        clk;
    logic        rst_n;
    logic [63:0] fetch_address;
    logic        fetch_req;
    logic [63:0] fetch_instruction;
    logic        fetch_done;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_instruction;
    logic [63:0] out_pc;

    fetch_unit #(
        .INSTRUCTIONSIZE (64),
        .RESET_PC        (RST_PC),
        .DEPTH           (DEPTH)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .fetch_address     (fetch_address),
        .fetch_req         (fetch_req),
        .fetch_instruction (fetch_instruction),
        .fetch_done        (fetch_done),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_instruction   (out_instruction),
        .out_pc            (out_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [63:0] pc;
        logic [63:0] instr;
    } ent_t;

    ent_t        exp_q[$];
    logic [63:0] m_pc;
    bit          m_out;
    bit          m_drop;
    int          mmu_lat;
    int          mmu_cnt;
    int          cyc_n;
    logic [63:0] iss_addr[$];
    int          iss_cyc[$];
    int          n_cmp;
    int          n_bad;

    function automatic logic [63:0] align(input logic [63:0] a);
        return (a / STEP) * STEP;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // One clock: check outputs, advance the reference across the edge, then drive the MMU.
    task automatic cyc();
        logic        req_b, done_b, redir_b, rdy_b, exp_req, accepted;
        logic [63:0] addr_b, rpc_b, instr_b, exp_addr;
        int          sz_b;
        ent_t        e;
        req_b   = fetch_req;
        addr_b  = fetch_address;
        done_b  = fetch_done;
        instr_b = fetch_instruction;
        redir_b = redirect_valid;
        rpc_b   = redirect_pc;
        rdy_b   = out_ready;
        sz_b    = exp_q.size();
        chk1("out_valid", out_valid, sz_b > 0);
        if (sz_b > 0) begin
            chk("out_pc", out_pc, exp_q[0].pc);
            chk("out_instruction", out_instruction, exp_q[0].instr);
        end
        @(posedge clk);
        #1;
        cyc_n++;
        redirect_valid = 1'b0;
        accepted = done_b && m_out;
        if (accepted) m_out = 1'b0;
        if (redir_b) begin
            exp_q.delete();
            m_pc = align(rpc_b);
            if (m_out) m_drop = 1'b1;
            else if (accepted) m_drop = 1'b0;
        end else begin
            if (rdy_b && sz_b > 0) e = exp_q.pop_front();
            if (accepted) begin
                if (m_drop) begin
                    m_drop = 1'b0;
                end else begin
                    e.pc = m_pc;
                    e.instr = instr_b;
                    exp_q.push_back(e);
                    m_pc = m_pc + STEP;
                end
            end
        end
        exp_req  = req_b ? !done_b : (!redir_b && sz_b < DEPTH);
        exp_addr = req_b ? addr_b : m_pc;
        chk1("fetch_req", fetch_req, exp_req);
        if (exp_req) chk("fetch_address", fetch_address, exp_addr);
        if (fetch_req && !req_b) begin
            m_out = 1'b1;
            iss_addr.push_back(fetch_address);
            iss_cyc.push_back(cyc_n);
        end
        if (fetch_req) begin
            mmu_cnt++;
            if (mmu_cnt >= mmu_lat) begin
                fetch_done = 1'b1;
                fetch_instruction = {$urandom, $urandom};
                mmu_cnt = 0;
            end else begin
                fetch_done = 1'b0;
            end
        end else begin
            fetch_done = 1'b0;
            mmu_cnt = 0;
        end
    endtask

    // Pulls rst_n low for part of a cycle and follows it with a stray fetch_done.
    task automatic mid_reset();
        #1 rst_n = 1'b0;
        #1;
        chk1("rst_fetch_req", fetch_req, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk("rst_fetch_address", fetch_address, RST_PC);
        chk("rst_out_pc", out_pc, 64'h0);
        chk("rst_out_instruction", out_instruction, 64'h0);
        #2 rst_n = 1'b1;
        exp_q.delete();
        m_pc = RST_PC;
        m_out = 1'b0;
        m_drop = 1'b0;
        mmu_cnt = 0;
        redirect_valid = 1'b0;
        fetch_done = 1'b1;
        fetch_instruction = {$urandom, $urandom};
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc_n = 0;
        mmu_lat = 2;
        mmu_cnt = 0;
        m_pc = RST_PC;
        m_out = 1'b0;
        m_drop = 1'b0;
        rst_n = 1'b0;
        fetch_done = 1'b0;
        fetch_instruction = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b1;
        #12;
        chk1("reset_fetch_req", fetch_req, 1'b0);
        chk1("reset_out_valid", out_valid, 1'b0);
        chk("reset_fetch_address", fetch_address, RST_PC);
        chk("reset_out_pc", out_pc, 64'h0);
        chk("reset_out_instruction", out_instruction, 64'h0);
        #1 rst_n = 1'b1;

        // Steady stream, MMU latency 2, decode always ready.
        for (int k = 0; k < 30; k++) begin
            if (iss_addr.size() >= 3) break;
            cyc();
        end
        chk1("stream_reached", iss_addr.size() >= 3, 1'b1);
        chk("stream_addr0", iss_addr[0], 64'h1000);
        chk("stream_addr1", iss_addr[1], 64'h1008);
        chk("stream_addr2", iss_addr[2], 64'h1010);
        chk("stream_gap01", 64'(iss_cyc[1] - iss_cyc[0]), 64'd3);
        chk("stream_gap12", 64'(iss_cyc[2] - iss_cyc[1]), 64'd3);

        // Async reset while a request is outstanding, then backpressure from a clean start.
        for (int k = 0; k < 10; k++) begin
            if (fetch_req && !fetch_done) break;
            cyc();
        end
        chk1("wait_before_reset", fetch_req && !fetch_done, 1'b1);
        mid_reset();
        out_ready = 1'b0;
        iss_addr.delete();
        iss_cyc.delete();
        cyc();
        chk1("late_done_no_push", out_valid, 1'b0);
        for (int k = 0; k < 20; k++) cyc();
        chk("bp_issue_count", 64'(iss_addr.size()), 64'd2);
        chk("bp_addr0", iss_addr[0], 64'h1000);
        chk("bp_addr1", iss_addr[1], 64'h1008);
        chk1("bp_req_idle", fetch_req, 1'b0);
        chk("bp_head_pc", out_pc, 64'h1000);
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (iss_addr.size() >= 3) break;
            cyc();
        end
        chk("bp_resume_addr", iss_addr[2], 64'h1010);

        // Redirect while the 0x1008 request is outstanding.
        mid_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (fetch_req && fetch_address == 64'h1008 && !fetch_done) break;
            cyc();
        end
        chk1("redir_wait_reached", fetch_req && fetch_address == 64'h1008 && !fetch_done, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc = 64'h2004;
        cyc();
        chk1("redir_flushed", out_valid, 1'b0);
        iss_addr.delete();
        iss_cyc.delete();
        for (int k = 0; k < 20; k++) begin
            if (iss_addr.size() >= 1) break;
            cyc();
        end
        chk("redir_target", iss_addr[0], 64'h2000);
        for (int k = 0; k < 20; k++) begin
            if (out_valid) break;
            cyc();
        end
        chk("redir_first_bundle", out_pc, 64'h2000);

        // Redirect coincident with fetch_done and a pop.
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h3000;
        cyc();
        for (int k = 0; k < 30; k++) begin
            if (fetch_done && exp_q.size() == 1) break;
            cyc();
        end
        chk1("coinc_reached", fetch_done && out_valid, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc = 64'h4000;
        out_ready = 1'b1;
        cyc();
        chk1("coinc_empty", out_valid, 1'b0);
        iss_addr.delete();
        iss_cyc.delete();
        for (int k = 0; k < 20; k++) begin
            if (iss_addr.size() >= 1) break;
            cyc();
        end
        chk("coinc_target", iss_addr[0], 64'h4000);
        for (int k = 0; k < 20; k++) begin
            if (out_valid) break;
            cyc();
        end
        chk("coinc_first_bundle", out_pc, 64'h4000);

        // PC wraps modulo 2^64.
        redirect_valid = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        cyc();
        iss_addr.delete();
        iss_cyc.delete();
        for (int k = 0; k < 30; k++) begin
            if (iss_addr.size() >= 2) break;
            cyc();
        end
        chk("wrap_addr0", iss_addr[0], 64'hFFFF_FFFF_FFFF_FFF8);
        chk("wrap_addr1", iss_addr[1], 64'h0);

        // Random decode backpressure, MMU latency and redirects.
        for (int k = 0; k < 600; k++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!fetch_req) mmu_lat = $urandom_range(1, 3);
            if ($urandom_range(0, 15) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = {$urandom, $urandom};
            end
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front-end stage that sits directly upstream of the instruction MMU/cache.
- Owns the program counter and drives the MMU fetch request (address, doFetch); consumes the returned little-endian instruction word and doneFetch.
- Buffers returned bundles in a small FIFO, each tagged with its PC, and presents them to decode through a valid/ready handshake.
- Handles redirects from branch/exception logic by flushing the FIFO and discarding stale in-flight responses.

Parameters:
- INSTRUCTIONSIZE, 64, bundle width in bits. Must be a multiple of 8 and a power of two ≥ 8.
- RESET_PC, 64'h0, PC loaded at reset.
- DEPTH, 2, output FIFO entries (power of two, ≥ 2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- fetch_address  out  64  byte address to MMU
- fetch_req  out  1  drives MMU doFetch
- fetch_instruction  in  INSTRUCTIONSIZE  MMU instruction (already byte-swapped)
- fetch_done  in  1  MMU doneFetch; one-cycle pulse, instruction valid same cycle
- redirect_valid  in  1  one-cycle redirect request
- redirect_pc  in  64  redirect target
- out_valid  out  1  bundle available to decode
- out_ready  in  1  decode accepts
- out_instruction  out  INSTRUCTIONSIZE  head bundle
- out_pc  out  64  PC of head bundle

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - pc = RESET_PC; fetch_address = RESET_PC.
  - fetch_req = 0, out_valid = 0, out_instruction = 0, out_pc = 0.
  - FIFO empty; state IDLE; drop flag = 0.
- Constants: STEP = INSTRUCTIONSIZE/8. ALIGN = log2(STEP) low address bits, always forced to 0 on any PC load.
- FSM states: IDLE, WAIT.
  - IDLE: if (count + 0) < DEPTH and no redirect this cycle → next cycle fetch_req = 1, fetch_address = pc, go WAIT.
  - WAIT: fetch_req and fetch_address held stable until the fetch_done cycle. On fetch_done:
    - fetch_req drops the next cycle.
    - If drop = 0: push {fetch_instruction, pc}, pc += STEP.
    - If drop = 1: discard the response, clear drop.
    - Go to IDLE.
- Issue latency: one cycle spent in IDLE between consecutive requests. Back-to-back throughput is one bundle per (MMU latency + 1) cycles.
- Space check is done at issue time. A push can never find the FIFO full, because at most one request is outstanding and issue requires count < DEPTH. Assert this.
- FIFO and output:
  - out_valid = (count > 0); out_instruction and out_pc come from the head entry, registered.
  - Pop when out_valid && out_ready. Push and pop in the same cycle leave count unchanged.
- Redirect (highest priority):
  - pc ← redirect_pc with ALIGN bits cleared. FIFO flushed (count = 0, out_valid = 0 next cycle).
  - A pop in the same cycle is ignored.
  - In WAIT without fetch_done: set drop = 1. fetch_req stays asserted until fetch_done, because the MMU cannot be cancelled.
  - In WAIT with fetch_done in the same cycle: the response is discarded, no push, go IDLE.
  - In IDLE: no request is issued that cycle; the new pc is fetched from the next cycle.
  - A second redirect while drop = 1 updates pc only.
- Arithmetic: pc increment is modulo 2^64. 64'hFFFF_FFFF_FFFF_FFF8 + 8 → 0 when STEP = 8.
- Reset mid-operation: all state returns to reset values immediately. Any later fetch_done arriving while in IDLE is ignored.

Decomposition:
- Shared package fetch_pkg:
  - typedef fetch_entry_t {instruction, pc}
  - enum fetch_state_t {IDLE, WAIT}
  - function pc_align()
- One natural sub-module: fetch_fifo. A parameterised synchronous FIFO with push, pop, flush, count and head outputs, on the same async active-low reset.

Test Plan:
- Reset then steady stream:
  - Stimulus: RESET_PC = 0x1000, MMU latency 2, out_ready = 1.
  - Required: fetch_address sequence 0x1000, 0x1008, 0x1010; out_pc matches with the correct bundles; no bubbles beyond the IDLE cycle.
- Backpressure:
  - Stimulus: out_ready = 0.
  - Required: exactly DEPTH = 2 bundles are fetched, then fetch_req stays 0. Raising out_ready resumes at 0x1010.
- Redirect during WAIT:
  - Stimulus: redirect_pc = 0x2004 while a 0x1008 request is outstanding.
  - Required: the 0x1008 response is discarded, the FIFO is flushed, and the next fetch_address is 0x2000 (aligned).
- Redirect coincident with fetch_done and a pop:
  - Required: no push, no pop effect, FIFO empty; next request goes to the redirect target.
- Wrap-around:
  - Stimulus: RESET_PC = 64'hFFFF_FFFF_FFFF_FFF8.
  - Required: second fetch_address = 0.
- Async reset mid-WAIT:
  - Stimulus: rst_n low for a partial cycle.
  - Required: outputs reset immediately. A late fetch_done produces no push, and fetching restarts at RESET_PC.
